// File: rtl/arb_pkg.sv
// Shared types and constants for the CPU/DMA memory arbiter.
//   state_e : arbiter FSM states (IDLE, ISSUE, RESP)
//   owner_e : which requester holds the current transaction
//   MMIO_SW_ADDR / MMIO_LED_ADDR : memory-mapped switch and LED registers
package arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_e;

  localparam logic [15:0] MMIO_SW_ADDR  = 16'hFFFF;
  localparam logic [15:0] MMIO_LED_ADDR = 16'hFFFE;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clock : sampling clock
//   reset : synchronous active-low reset, clears both stages
//   d     : asynchronous input bus
//   q     : synchronized output, two rising edges behind d
module sync2 #(
  parameter int unsigned Width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single synchronous RAM port, with
// memory-mapped switch (read, 16'hFFFF) and LED (read/write, 16'hFFFE) registers.
// Each transaction runs IDLE -> ISSUE -> RESP; the owner sees a one-cycle ack in RESP.
//   clock, reset                 : system clock, synchronous active-low reset
//   cpu_*/dma_* req,we,addr,wdata: requester inputs, held until ack
//   cpu_ack/dma_ack, *_rdata     : completion pulse and read data
//   mem_addr/mem_wdata/mem_we    : RAM port (read data returned one cycle later)
//   mem_rdata                    : RAM read data
//   switches                     : asynchronous board switches
//   leds                         : LED register
// Build option: define MEM_ARBITER_ROUND_ROBIN_EN for round-robin contention
// resolution; otherwise the CPU always wins contention.
module mem_arbiter
  import arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] switches,
  output logic [15:0] leds
);

  state_e      state_q;
  owner_e      owner_q;
  logic [15:0] addr_q, wdata_q;
  logic        we_q;
  logic [15:0] cpu_rdata_q, dma_rdata_q;
  logic [15:0] sw_sync;

  logic        grant_cpu;
  logic [15:0] g_addr, g_wdata;
  logic        g_we;
  logic        ram_read;
  logic        mmio_read;
  logic [15:0] mmio_rdata;

  sync2 #(
    .Width(16)
  ) u_sw_sync (
    .clock(clock),
    .reset(reset),
    .d    (switches),
    .q    (sw_sync)
  );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  owner_e last_grant_q;
  // On contention the requester that was not served last wins.
  assign grant_cpu = cpu_req && (!dma_req || (last_grant_q == OWN_DMA));
`else
  assign grant_cpu = cpu_req;
`endif

  assign g_addr  = grant_cpu ? cpu_addr  : dma_addr;
  assign g_wdata = grant_cpu ? cpu_wdata : dma_wdata;
  assign g_we    = grant_cpu ? cpu_we    : dma_we;

  // Addresses below the MMIO window go to RAM.
  assign ram_read = !we_q && (addr_q < MMIO_LED_ADDR);

  always_comb begin
    mmio_read  = 1'b0;
    mmio_rdata = '0;
    if (!we_q && (addr_q == MMIO_SW_ADDR)) begin
      mmio_read  = 1'b1;
      mmio_rdata = sw_sync;
    end else if (!we_q && (addr_q == MMIO_LED_ADDR)) begin
      mmio_read  = 1'b1;
      mmio_rdata = leds;
    end
  end

  // RAM data arrives during RESP, the same cycle as ack, so it is forwarded
  // straight through then and captured to hold once RESP ends.
  assign cpu_rdata = (state_q == RESP && owner_q == OWN_CPU && ram_read) ? mem_rdata
                                                                          : cpu_rdata_q;
  assign dma_rdata = (state_q == RESP && owner_q == OWN_DMA && ram_read) ? mem_rdata
                                                                          : dma_rdata_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      leds         <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_q <= OWN_DMA;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner_q      <= grant_cpu ? OWN_CPU : OWN_DMA;
            addr_q       <= g_addr;
            wdata_q      <= g_wdata;
            we_q         <= g_we;
            mem_addr     <= g_addr;
            mem_wdata    <= g_wdata;
            mem_we       <= g_we && (g_addr < MMIO_LED_ADDR);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q <= grant_cpu ? OWN_CPU : OWN_DMA;
`endif
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_we    <= 1'b0;
          if (we_q && (addr_q == MMIO_LED_ADDR)) begin
            leds <= wdata_q;
          end
          if (mmio_read) begin
            if (owner_q == OWN_CPU) cpu_rdata_q <= mmio_rdata;
            else                    dma_rdata_q <= mmio_rdata;
          end
          if (owner_q == OWN_CPU) cpu_ack <= 1'b1;
          else                    dma_ack <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          if (ram_read) begin
            if (owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
            else                    dma_rdata_q <= mem_rdata;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [15:0] switches = '0;
  logic [15:0] leds;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .dma_req  (dma_req),
    .dma_we   (dma_we),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_ack  (dma_ack),
    .dma_rdata(dma_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .switches (switches),
    .leds     (leds)
  );

  // Behavioural synchronous RAM, 1K words, read data one cycle after address.
  logic [15:0] ram [1024];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[9:0]];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One transaction from a single requester; inputs change on negedges.
  task automatic txn(input bit dma, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, output int ack_cyc, output logic [15:0] rdata,
                     output int we_cnt, output logic [15:0] issue_addr, output int other_ack,
                     output bit ack_after);
    if (dma) begin
      dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    ack_cyc = -1; rdata = '0; we_cnt = 0; issue_addr = '0; other_ack = 0;
    for (int c = 1; c <= 8 && ack_cyc < 0; c++) begin
      @(negedge clock);
      if (mem_we) we_cnt++;
      if (c == 1) issue_addr = mem_addr;
      if (dma ? cpu_ack : dma_ack) other_ack++;
      if (dma ? dma_ack : cpu_ack) begin
        ack_cyc = c;
        rdata   = dma ? dma_rdata : cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clock);
    ack_after = cpu_ack | dma_ack;
  endtask

  typedef struct {
    bit          dma;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_we;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t        vecs[12];
  bit          exp_order[4];
  bit          got_order[4];
  int          ack_cyc, we_cnt, other_ack, n_acks, cyc;
  logic [15:0] rdata, issue_addr;
  logic [15:0] last_cpu_rd, last_dma_rd;
  bit          ack_after, both_ack;

  initial begin
    vecs[0]  = '{0, 1, 16'h0010, 16'hBEEF, 16'h0000, 1, 16'h0000};
    vecs[1]  = '{0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 16'h0000};
    vecs[2]  = '{1, 1, 16'h0020, 16'h1234, 16'h0000, 1, 16'h0000};
    vecs[3]  = '{1, 0, 16'h0020, 16'h0000, 16'h1234, 0, 16'h0000};
    vecs[4]  = '{0, 0, 16'h0020, 16'h0000, 16'h1234, 0, 16'h0000};
    vecs[5]  = '{0, 1, 16'hFFFE, 16'h00A5, 16'h0000, 0, 16'h00A5};
    vecs[6]  = '{0, 0, 16'hFFFE, 16'h0000, 16'h00A5, 0, 16'h00A5};
    vecs[7]  = '{0, 0, 16'hFFFF, 16'h0000, 16'h0007, 0, 16'h00A5};
    vecs[8]  = '{1, 1, 16'hFFFF, 16'h9999, 16'h0000, 0, 16'h00A5};
    vecs[9]  = '{1, 0, 16'hFFFE, 16'h0000, 16'h00A5, 0, 16'h00A5};
    vecs[10] = '{0, 1, 16'hFFFD, 16'h7777, 16'h0000, 1, 16'h00A5};
    vecs[11] = '{1, 0, 16'hFFFD, 16'h0000, 16'h7777, 0, 16'h00A5};
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    // Reset state.
    switches = 16'h0007;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dma_ack", dma_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_leds", leds, 0);
    reset = 1'b1;
    @(negedge clock);

    // Contention with both requests held through four transactions.
    cpu_we = 1'b0; cpu_addr = 16'h0100;
    dma_we = 1'b0; dma_addr = 16'h0200;
    cpu_req = 1'b1; dma_req = 1'b1;
    n_acks = 0; both_ack = 1'b0;
    for (cyc = 0; cyc < 40 && n_acks < 4; cyc++) begin
      @(negedge clock);
      if (cpu_ack && dma_ack) both_ack = 1'b1;
      if (cpu_ack || dma_ack) begin
        got_order[n_acks] = dma_ack;
        n_acks++;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clock);
    check("contend_acks", n_acks, 4);
    check("contend_both_ack", both_ack, 0);
    for (int i = 0; i < 4; i++) begin
      if (i < n_acks) check($sformatf("contend_grant%0d", i), got_order[i], exp_order[i]);
    end

    // Table-driven single-requester transactions.
    last_cpu_rd = cpu_rdata;
    last_dma_rd = dma_rdata;
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].dma, vecs[i].we, vecs[i].addr, vecs[i].wdata,
          ack_cyc, rdata, we_cnt, issue_addr, other_ack, ack_after);
      check($sformatf("v%0d_latency", i), ack_cyc, 2);
      check($sformatf("v%0d_mem_we_cycles", i), we_cnt, vecs[i].exp_we);
      check($sformatf("v%0d_issue_addr", i), issue_addr, vecs[i].addr);
      check($sformatf("v%0d_other_ack", i), other_ack, 0);
      check($sformatf("v%0d_ack_one_cycle", i), ack_after, 0);
      check($sformatf("v%0d_leds", i), leds, vecs[i].exp_leds);
      check($sformatf("v%0d_idle_mem_addr", i), mem_addr, 0);
      if (!vecs[i].we) begin
        check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        if (vecs[i].dma) last_dma_rd = vecs[i].exp_rdata;
        else             last_cpu_rd = vecs[i].exp_rdata;
      end
      if (vecs[i].dma) check($sformatf("v%0d_cpu_rdata_hold", i), cpu_rdata, last_cpu_rd);
      else             check($sformatf("v%0d_dma_rdata_hold", i), dma_rdata, last_dma_rd);
    end

    // Switch change seen through the synchronizer.
    switches = 16'h0005;
    repeat (3) @(negedge clock);
    txn(0, 0, 16'hFFFF, 16'h0000, ack_cyc, rdata, we_cnt, issue_addr, other_ack, ack_after);
    check("sw_change_rdata", rdata, 16'h0005);

    // Request dropped during ISSUE still completes.
    cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_req = 1'b1;
    @(negedge clock);
    cpu_req = 1'b0;
    @(negedge clock);
    check("drop_ack", cpu_ack, 1);
    check("drop_rdata", cpu_rdata, 16'h1234);
    @(negedge clock);
    check("drop_ack_low", cpu_ack, 0);

    // Reset during ISSUE of a DMA write aborts it.
    dma_we = 1'b1; dma_addr = 16'h0040; dma_wdata = 16'hDEAD; dma_req = 1'b1;
    @(negedge clock);
    check("abort_in_issue_we", mem_we, 1);
    reset = 1'b0;
    cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    @(negedge clock);
    check("abort_dma_ack", dma_ack, 0);
    check("abort_mem_we", mem_we, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_leds", leds, 0);
    @(negedge clock);
    check("abort_hold_acks", cpu_ack | dma_ack, 0);
    reset = 1'b1;
    ack_cyc = -1;
    for (int c = 1; c <= 8 && ack_cyc < 0; c++) begin
      @(negedge clock);
      if (cpu_ack || dma_ack) begin
        ack_cyc = c;
        check("post_rst_cpu_wins", {cpu_ack, dma_ack}, 2'b10);
        check("post_rst_rdata", cpu_rdata, 16'hBEEF);
      end
    end
    check("post_rst_latency", ack_cyc, 2);
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Port clock input 1: single system clock; all state updates on its rising edge.
REQ-002 Port reset input 1: reset is synchronous and active-low.
REQ-003 Port cpu_req/cpu_we input 1 each, cpu_addr/cpu_wdata input 16 each: CPU request, level, held stable until cpu_ack.
REQ-004 Port cpu_ack output 1, cpu_rdata output 16: one-cycle completion pulse; read data valid while cpu_ack=1.
REQ-005 Port dma_req/dma_we input 1 each, dma_addr/dma_wdata input 16 each; dma_ack output 1, dma_rdata output 16: second requester, same protocol as CPU.
REQ-006 Port mem_addr/mem_wdata output 16 each, mem_we output 1, mem_rdata input 16: shared synchronous RAM port, read data one cycle after address.
REQ-007 Port switches input 16: asynchronous board switches; leds output 16: LED register.

Function
REQ-008 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE when any req=1, ISSUE->RESP always, RESP->IDLE always.
REQ-009 Owner latched on IDLE->ISSUE; owner's addr/we/wdata captured into internal registers at that edge.
REQ-010 Latency: req sampled high at edge N (IDLE) -> mem access during cycle N+1 (ISSUE) -> owner ack=1 during cycle N+2 (RESP), exactly one cycle.
REQ-011 Requester deasserts req on the edge where it samples ack=1; req still high in following IDLE = new transaction.
REQ-012 Non-owner ack=0 always; non-owner rdata holds last value driven to it.
REQ-013 mem_addr = captured address in ISSUE, 0 otherwise; mem_we=1 only in ISSUE for a write to address below 16'hFFFE.
REQ-014 MMIO: address 16'hFFFF read returns synchronized switches, write ignored; 16'hFFFE write loads leds at ISSUE edge, read returns leds; neither touches mem_we.
REQ-015 RAM read: owner rdata = mem_rdata sampled during RESP; MMIO read data registered in ISSUE, presented in RESP.
REQ-016 Simultaneous cpu_req and dma_req in IDLE resolved per REQ-022/REQ-023; loser waits, no starvation of granted transaction.
REQ-017 req dropped by a requester mid-transaction: transaction completes, ack still pulses.
REQ-018 Switch input passed through two-flop synchronizer; MMIO read reflects switch value two edges after change.

Reset
REQ-019 reset=0 sampled at a clock edge: state=IDLE, cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, leds=0, synchronizer flops=0, last-grant=DMA.
REQ-020 reset asserted mid-ISSUE or mid-RESP aborts transaction: no ack issued, no pending write completed after reset edge.
REQ-021 First grant after reset release no earlier than first edge with reset=1 and req=1.

Configuration
REQ-022 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: on contention, grant requester not granted last; last-grant updated every IDLE->ISSUE.
REQ-023 Macro undefined: fixed priority, CPU always wins contention; last-grant register absent.

Structure
REQ-024 Package arb_pkg holds state enum (IDLE, ISSUE, RESP), owner type (OWN_CPU, OWN_DMA), constants MMIO_SW_ADDR=16'hFFFF, MMIO_LED_ADDR=16'hFFFE.
REQ-025 One sub-module sync2 (parameter width 16) for switch synchronization; arbitration and FSM inline.

Verification
REQ-026 CPU write 0x0010<=0xBEEF, then read 0x0010 -> mem_we=1 one cycle, mem_addr=0x0010; read cpu_ack at N+2 with cpu_rdata=0xBEEF.
REQ-027 cpu_req and dma_req both rise same edge, held through 4 transactions -> round-robin build: CPU,DMA,CPU,DMA; fixed build: CPU,CPU,CPU,CPU.
REQ-028 switches=0x0007, CPU reads 0xFFFF -> rdata=0x0007; switches->0x0005, read after 3 cycles -> 0x0005.
REQ-029 CPU writes 0xFFFE<=0x00A5 -> leds=0x00A5 after ISSUE edge, mem_we stays 0; read 0xFFFE -> 0x00A5.
REQ-030 reset=0 during ISSUE of a DMA write -> no dma_ack, mem_we=0 after reset edge, leds=0, next request served normally with CPU winning contention.
